// File: rtl/rnn_mem_pkg.sv
// Bank encodings, depths and widths for the RNN weight/IO memory; shared with the RNN core.
// addr_ok() is the single definition of a legal (sel, addr) pair.
package rnn_mem_pkg;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 20;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] SEL_IN   = 3'd0;
  localparam logic [SEL_W-1:0] SEL_WIH  = 3'd1;
  localparam logic [SEL_W-1:0] SEL_WHH  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_BIAS = 3'd3;
  localparam logic [SEL_W-1:0] SEL_LEN  = 3'd4;
  localparam logic [SEL_W-1:0] SEL_OUT  = 3'd5;

  // One extra bit so the output bank depth (2^ADDR_W) is representable.
  localparam logic [ADDR_W:0] DEPTH_IN   = 18'd2048;
  localparam logic [ADDR_W:0] DEPTH_WIH  = 18'd64;
  localparam logic [ADDR_W:0] DEPTH_WHH  = 18'd4096;
  localparam logic [ADDR_W:0] DEPTH_BIAS = 18'd64;
  localparam logic [ADDR_W:0] DEPTH_LEN  = 18'd1;
  localparam logic [ADDR_W:0] DEPTH_OUT  = 18'd131072;

  function automatic logic addr_ok(input logic [SEL_W-1:0] sel, input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] a;
    a = {1'b0, addr};
    case (sel)
      SEL_IN:   return a < DEPTH_IN;
      SEL_WIH:  return a < DEPTH_WIH;
      SEL_WHH:  return a < DEPTH_WHH;
      SEL_BIAS: return a < DEPTH_BIAS;
      SEL_LEN:  return a < DEPTH_LEN;
      SEL_OUT:  return a < DEPTH_OUT;
      default:  return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/rnn_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter (0=core, 1=host) with burst lock and starvation cap.
// Grant is combinational from req/lock and registered owner/last/burst state.
module rr_arb2 #(
  parameter int MAX_BURST = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic             last_q, last_d;
  logic             own_vld_q, own_vld_d;
  logic             own_id_q, own_id_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             keep, any, gid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      own_vld_q <= 1'b0;
      own_id_q  <= 1'b0;
      burst_q   <= '0;
    end else begin
      last_q    <= last_d;
      own_vld_q <= own_vld_d;
      own_id_q  <= own_id_d;
      burst_q   <= burst_d;
    end
  end

  always_comb begin
    last_d    = last_q;
    own_vld_d = 1'b0;
    own_id_d  = own_id_q;
    burst_d   = '0;
    if (any) begin
      last_d = gid;
      if (lock_i[gid]) begin
        own_vld_d = 1'b1;
        own_id_d  = gid;
        if (keep)
          burst_d = (burst_q == CNT_W'(MAX_BURST)) ? burst_q : burst_q + CNT_W'(1);
        else
          burst_d = CNT_W'(1);
      end
    end
  end

  // A capped owner keeps going only while the other side stays idle.
  always_comb begin
    any  = |req_i;
    keep = own_vld_q && req_i[own_id_q] && lock_i[own_id_q] &&
           !((burst_q >= CNT_W'(MAX_BURST)) && req_i[~own_id_q]);
    gid  = 1'b0;
    if (keep)                gid = own_id_q;
    else if (req_i == 2'b10) gid = 1'b1;
    else if (req_i == 2'b11) gid = ~last_q;
    gnt_o    = any ? (gid ? 2'b10 : 2'b01) : 2'b00;
    gnt_id_o = gid;
  end
endmodule

// File: rtl/rnn_mem_arbiter.sv
// Shares the RNN weight/IO memory between core and host: range check, registered memory drive,
// 2-stage read tag pipeline (rvalid at T+2), sticky error flag. No backpressure beyond the grant.
module rnn_mem_arbiter
  import rnn_mem_pkg::*;
#(
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              h_req,
  input  logic              c_lock,
  input  logic              h_lock,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [SEL_W-1:0]  c_sel,
  input  logic [SEL_W-1:0]  h_sel,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              c_gnt,
  output logic              h_gnt,
  output logic              c_rvalid,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              err_id,
  output logic              mce,
  output logic [ADDR_W-1:0] maddr,
  output logic [SEL_W-1:0]  msel,
  output logic [DATA_W-1:0] mdata_w,
  input  logic [DATA_W-1:0] mdata_r
);
  logic [1:0]        gnt;
  logic              gid, acc, ok;
  logic [SEL_W-1:0]  a_sel;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;

  logic              mce_q, mce_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [SEL_W-1:0]  msel_q, msel_d;
  logic [DATA_W-1:0] mdata_w_q, mdata_w_d;
  logic              t1_vld_q, t1_vld_d, t1_id_q, t1_id_d;
  logic              t2_vld_q, t2_vld_d, t2_id_q, t2_id_d;
  logic              err_q, err_d, err_id_q, err_id_d;

  rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({h_req, c_req}),
    .lock_i   ({h_lock, c_lock}),
    .gnt_o    (gnt),
    .gnt_id_o (gid)
  );

  always_comb begin
    a_sel   = gid ? h_sel   : c_sel;
    a_addr  = gid ? h_addr  : c_addr;
    a_wdata = gid ? h_wdata : c_wdata;
    acc     = |gnt;
    ok      = addr_ok(a_sel, a_addr);
  end

  // Out-of-range accesses are still granted but never reach the memory.
  always_comb begin
    mce_d     = acc && ok;
    maddr_d   = maddr_q;
    msel_d    = msel_q;
    mdata_w_d = mdata_w_q;
    if (mce_d) begin
      maddr_d   = a_addr;
      msel_d    = a_sel;
      mdata_w_d = a_wdata;
    end
    t1_vld_d = mce_d && (a_sel != SEL_OUT);
    t1_id_d  = gid;
    t2_vld_d = t1_vld_q;
    t2_id_d  = t1_id_q;
    err_d    = err_q | (acc && !ok);
    err_id_d = err_id_q;
    if (acc && !ok && !err_q) err_id_d = gid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mce_q     <= 1'b0;
      maddr_q   <= '0;
      msel_q    <= '0;
      mdata_w_q <= '0;
      t1_vld_q  <= 1'b0;
      t1_id_q   <= 1'b0;
      t2_vld_q  <= 1'b0;
      t2_id_q   <= 1'b0;
      err_q     <= 1'b0;
      err_id_q  <= 1'b0;
    end else begin
      mce_q     <= mce_d;
      maddr_q   <= maddr_d;
      msel_q    <= msel_d;
      mdata_w_q <= mdata_w_d;
      t1_vld_q  <= t1_vld_d;
      t1_id_q   <= t1_id_d;
      t2_vld_q  <= t2_vld_d;
      t2_id_q   <= t2_id_d;
      err_q     <= err_d;
      err_id_q  <= err_id_d;
    end
  end

  assign c_gnt    = gnt[0];
  assign h_gnt    = gnt[1];
  assign c_rvalid = t2_vld_q & ~t2_id_q;
  assign h_rvalid = t2_vld_q &  t2_id_q;
  assign rdata    = mdata_r;
  assign err      = err_q;
  assign err_id   = err_id_q;
  assign mce      = mce_q;
  assign maddr    = maddr_q;
  assign msel     = msel_q;
  assign mdata_w  = mdata_w_q;
endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// Directed bench for rnn_mem_arbiter (MAX_BURST=4): cycle table for arbitration/lock, hand sequences
// for single read, write, out-of-range and reset with reads in flight.
module tb_rnn_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, h_req, c_lock, h_lock;
  logic [16:0] c_addr, h_addr;
  logic [2:0]  c_sel, h_sel;
  logic [19:0] c_wdata, h_wdata;
  logic        c_gnt, h_gnt, c_rvalid, h_rvalid, err, err_id, mce;
  logic [19:0] rdata, mdata_w, mdata_r;
  logic [16:0] maddr;
  logic [2:0]  msel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rnn_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .h_req(h_req), .c_lock(c_lock), .h_lock(h_lock),
    .c_addr(c_addr), .h_addr(h_addr), .c_sel(c_sel), .h_sel(h_sel),
    .c_wdata(c_wdata), .h_wdata(h_wdata),
    .c_gnt(c_gnt), .h_gnt(h_gnt), .c_rvalid(c_rvalid), .h_rvalid(h_rvalid),
    .rdata(rdata), .err(err), .err_id(err_id),
    .mce(mce), .maddr(maddr), .msel(msel), .mdata_w(mdata_w), .mdata_r(mdata_r)
  );

  typedef struct {
    logic        c_req, c_lock;
    logic [16:0] c_addr;
    logic        h_req, h_lock;
    logic [16:0] h_addr;
    logic        e_cg, e_hg, e_mce, e_crv, e_hrv;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic cr, input logic cl, input logic [16:0] ca,
                              input logic hr, input logic hl, input logic [16:0] ha,
                              input logic cg, input logic hg, input logic m,
                              input logic crv, input logic hrv);
    vec_t v;
    v.c_req = cr; v.c_lock = cl; v.c_addr = ca;
    v.h_req = hr; v.h_lock = hl; v.h_addr = ha;
    v.e_cg = cg; v.e_hg = hg; v.e_mce = m; v.e_crv = crv; v.e_hrv = hrv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    c_req = 0; c_lock = 0; c_addr = '0; c_sel = '0; c_wdata = '0;
    h_req = 0; h_lock = 0; h_addr = '0; h_sel = '0; h_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // core reads bank 0, host reads bank 2
    tbl[0]  = mk(1,0,17'd0,  1,0,17'd100, 1,0,0,0,0);
    tbl[1]  = mk(1,0,17'd1,  1,0,17'd101, 0,1,1,0,0);
    tbl[2]  = mk(1,0,17'd2,  1,0,17'd102, 1,0,1,1,0);
    tbl[3]  = mk(1,0,17'd3,  1,0,17'd103, 0,1,1,0,1);
    tbl[4]  = mk(1,0,17'd4,  1,0,17'd104, 1,0,1,1,0);
    tbl[5]  = mk(1,0,17'd5,  1,0,17'd105, 0,1,1,0,1);
    tbl[6]  = mk(0,0,17'd0,  0,0,17'd0,   0,0,1,1,0);
    tbl[7]  = mk(0,0,17'd0,  0,0,17'd0,   0,0,0,0,1);
    tbl[8]  = mk(1,0,17'd8,  1,1,17'd108, 1,0,0,0,0);
    tbl[9]  = mk(1,0,17'd9,  1,1,17'd109, 0,1,1,0,0);
    tbl[10] = mk(1,0,17'd10, 1,1,17'd110, 0,1,1,1,0);
    tbl[11] = mk(1,0,17'd11, 1,1,17'd111, 0,1,1,0,1);
    tbl[12] = mk(1,0,17'd12, 1,1,17'd112, 0,1,1,0,1);
    tbl[13] = mk(1,0,17'd13, 1,1,17'd113, 1,0,1,0,1);
    tbl[14] = mk(1,0,17'd14, 1,1,17'd114, 0,1,1,0,1);
    tbl[15] = mk(0,0,17'd0,  0,0,17'd0,   0,0,1,1,0);
    tbl[16] = mk(0,0,17'd0,  0,0,17'd0,   0,0,0,0,1);

    idle();
    mdata_r = 20'h12345;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mce", mce, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_msel", msel, 0);
    chk("rst_mdata_w", mdata_w, 0);
    chk("rst_err", err, 0);
    chk("rst_err_id", err_id, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_h_rvalid", h_rvalid, 0);
    chk("rst_rdata", rdata, 20'h12345);
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      c_req = tbl[i].c_req; c_lock = tbl[i].c_lock; c_addr = tbl[i].c_addr; c_sel = 3'd0;
      h_req = tbl[i].h_req; h_lock = tbl[i].h_lock; h_addr = tbl[i].h_addr; h_sel = 3'd2;
      @(negedge clk);
      chk($sformatf("row%0d_c_gnt", i), c_gnt, tbl[i].e_cg);
      chk($sformatf("row%0d_h_gnt", i), h_gnt, tbl[i].e_hg);
      chk($sformatf("row%0d_mce", i), mce, tbl[i].e_mce);
      chk($sformatf("row%0d_c_rvalid", i), c_rvalid, tbl[i].e_crv);
      chk($sformatf("row%0d_h_rvalid", i), h_rvalid, tbl[i].e_hrv);
      next_cycle();
    end
    idle();

    // single core read
    c_req = 1; c_sel = 3'd1; c_addr = 17'd5;
    @(negedge clk);
    chk("rd_c_gnt", c_gnt, 1);
    chk("rd_h_gnt", h_gnt, 0);
    next_cycle(); idle();
    @(negedge clk);
    chk("rd_mce", mce, 1);
    chk("rd_maddr", maddr, 5);
    chk("rd_msel", msel, 1);
    next_cycle();
    mdata_r = 20'h0ABCD;
    @(negedge clk);
    chk("rd_c_rvalid", c_rvalid, 1);
    chk("rd_h_rvalid", h_rvalid, 0);
    chk("rd_rdata", rdata, 20'h0ABCD);
    next_cycle();

    // host write to the output bank
    h_req = 1; h_sel = 3'd5; h_addr = 17'h1FFFF; h_wdata = 20'hF0000;
    @(negedge clk);
    chk("wr_h_gnt", h_gnt, 1);
    next_cycle(); idle();
    @(negedge clk);
    chk("wr_mce", mce, 1);
    chk("wr_msel", msel, 5);
    chk("wr_maddr", maddr, 17'h1FFFF);
    chk("wr_mdata_w", mdata_w, 20'hF0000);
    next_cycle();
    @(negedge clk);
    chk("wr_c_rvalid", c_rvalid, 0);
    chk("wr_h_rvalid", h_rvalid, 0);
    next_cycle();

    // out of range: core bias addr 64, then host sel 7
    c_req = 1; c_sel = 3'd3; c_addr = 17'd64;
    @(negedge clk);
    chk("oor_c_gnt", c_gnt, 1);
    chk("oor_err_before", err, 0);
    next_cycle(); idle();
    h_req = 1; h_sel = 3'd7; h_addr = 17'd0;
    @(negedge clk);
    chk("oor_h_gnt", h_gnt, 1);
    chk("oor_mce1", mce, 0);
    chk("oor_err", err, 1);
    chk("oor_err_id1", err_id, 0);
    next_cycle(); idle();
    @(negedge clk);
    chk("oor_mce2", mce, 0);
    chk("oor_err_id2", err_id, 0);
    chk("oor_maddr_hold", maddr, 17'h1FFFF);
    chk("oor_c_rvalid1", c_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("oor_c_rvalid2", c_rvalid, 0);
    chk("oor_h_rvalid2", h_rvalid, 0);
    next_cycle();

    // two reads in flight, reset the cycle after the second grant
    c_req = 1; c_sel = 3'd0; c_addr = 17'd1;
    h_req = 1; h_sel = 3'd0; h_addr = 17'd2;
    @(negedge clk);
    chk("rip_c_gnt", c_gnt, 1);
    next_cycle();
    @(negedge clk);
    chk("rip_h_gnt", h_gnt, 1);
    next_cycle(); idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rip_mce", mce, 0);
    chk("rip_err", err, 0);
    chk("rip_c_rvalid", c_rvalid, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rip_h_rvalid", h_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("rip_c_rvalid2", c_rvalid, 0);
    chk("rip_h_rvalid2", h_rvalid, 0);
    next_cycle();
    c_req = 1; h_req = 1;
    @(negedge clk);
    chk("rip_tie_c_gnt", c_gnt, 1);
    chk("rip_tie_h_gnt", h_gnt, 0);
    next_cycle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
